cache_ctrl: RTL and testbench

Sequencing controller between the CPU-side request port and the fully associative cache (8-bit address, 32-bit data) plus a slower main memory. It serialises CPU read/write requests, drives the cache lookup and write ports, fills the cache from memory on a read miss, and writes every store through to memory. It also guards the memory handshake with a timeout and keeps saturating hit/miss statistics. The block sits directly above the `cache` datapath and owns all of that datapath's control inputs.

---
 rtl/cache_ctrl_pkg.sv | 22 ++
 rtl/sat_counter.sv | 34 +++
 rtl/cache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache sequencing controller.
//   state_e          controller FSM states
//   DefaultAddrW/DataW default datapath widths
//   CacheOpLookup/Write  encodings driven on cache_read while cache_en is high
package cache_ctrl_pkg;

    localparam int unsigned DefaultAddrW = 8;
    localparam int unsigned DefaultDataW = 32;

    localparam logic CacheOpLookup = 1'b1;
    localparam logic CacheOpWrite  = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCheck,
        StMemWait,
        StFill,
        StResp
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk    rising-edge clock
//   clr    synchronous clear (highest priority)
//   inc    increment enable; ignored once the count is all-ones
//   count  current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller between the CPU request port, a fully associative cache and main
// memory. Serialises requests, looks them up in the cache, fills on read miss, and writes every
// store through to memory (no write-allocate). Memory waits are bounded by TIMEOUT cycles.
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request, held until cpu_ack
//   cpu_ack/rdata/err             one-cycle completion with read data and timeout flag
//   cache_en/read/addr/wdata      cache strobe, op (1 lookup, 0 write/fill), address, data
//   cache_hit/rdata               lookup result, valid the cycle after the lookup strobe
//   mem_req/we/addr/wdata         memory request, held until mem_ready or timeout
//   mem_ready/rdata               memory completion pulse and read data
//   hit_cnt/miss_cnt              saturating lookup statistics
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefaultAddrW,
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              cache_en,
    output logic              cache_read,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    // Holds cache hit data or the memory fill word; stays 0 for writes and errors.
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              hit_inc, miss_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        err_d       = err_q;
        tmo_d       = '0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        cpu_ack     = 1'b0;
        cpu_rdata   = '0;
        cpu_err     = 1'b0;
        cache_en    = 1'b0;
        cache_read  = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                cache_en   = 1'b1;
                cache_read = CacheOpLookup;
                cache_addr = addr_q;
                state_d    = StCheck;
            end
            StCheck: begin
                if (cache_hit) begin
                    hit_inc = 1'b1;
                    if (we_q) begin
                        // Write hit: update the cached copy now, memory is written next.
                        cache_en    = 1'b1;
                        cache_read  = CacheOpWrite;
                        cache_addr  = addr_q;
                        cache_wdata = wdata_q;
                        state_d     = StMemWait;
                    end else begin
                        data_d  = cache_rdata;
                        state_d = StResp;
                    end
                end else begin
                    miss_inc = 1'b1;
                    state_d  = StMemWait;
                end
            end
            StMemWait: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = we_q ? wdata_q : '0;
                tmo_d     = tmo_q + 1'b1;
                // A ready arriving on the last allowed cycle still completes normally.
                if (mem_ready) begin
                    if (we_q) begin
                        state_d = StResp;
                    end else begin
                        data_d  = mem_rdata;
                        state_d = StFill;
                    end
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StFill: begin
                cache_en    = 1'b1;
                cache_read  = CacheOpWrite;
                cache_addr  = addr_q;
                cache_wdata = data_q;
                state_d     = StResp;
            end
            StResp: begin
                cpu_ack   = 1'b1;
                cpu_rdata = data_q;
                cpu_err   = err_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_miss_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl. The bench plays the cache and the memory, drives each
// transaction cycle by cycle and checks it against the expected sequence of phases; counters
// are modelled as plain saturating integers (narrow CNT_W so saturation is reachable).
module tb_cache_ctrl;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned TMO  = 16;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack, cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic          cache_en, cache_read;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_hit;
    logic [DW-1:0] cache_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] hit_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;
    int hits  = 0;
    int misses = 0;

    always #5 clk = ~clk;

    cache_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_err     (cpu_err),
        .cache_en    (cache_en),
        .cache_read  (cache_read),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_hit   (cache_hit),
        .cache_rdata (cache_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    function automatic logic [CW-1:0] sat(input int n);
        return (n > CMAX) ? CW'(CMAX) : CW'(n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction. lat = index of the memory-wait cycle carrying mem_ready; lat >= TMO
    // means memory never answers.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic hit, input logic [DW-1:0] hdata, input int lat,
                           input logic [DW-1:0] mdata);
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        step();
        // Lookup cycle: scramble CPU inputs and the cache result, both must be ignored.
        cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = $urandom;
        cache_hit = 1'($urandom); cache_rdata = $urandom;
        #1;
        total++;
        if ({cache_en, cache_read, cache_addr, cpu_ack, mem_req} !== {1'b1, 1'b1, addr, 2'b00}) begin
            bad++;
            $display("FAIL lookup en/rd/addr/ack/req got=%b/%b/%h/%b/%b want=1/1/%h/0/0",
                     cache_en, cache_read, cache_addr, cpu_ack, mem_req, addr);
        end
        step();
        cache_hit = hit; cache_rdata = hdata;
        #1;
        if (hit) hits++; else misses++;
        total++;
        if (cache_en !== (we && hit) || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL check_strobe en/req got=%b/%b want=%b/0", cache_en, mem_req, we && hit);
        end
        if (we && hit) begin
            total++;
            if ({cache_read, cache_addr, cache_wdata} !== {1'b0, addr, wdata}) begin
                bad++;
                $display("FAIL write_hit_update rd/addr/data got=%b/%h/%h want=0/%h/%h",
                         cache_read, cache_addr, cache_wdata, addr, wdata);
            end
        end
        step();
        cache_hit = 1'($urandom); cache_rdata = $urandom;
        exp_err = 1'b0;
        exp_rdata = '0;
        if (!we && hit) begin
            exp_rdata = hdata;
        end else begin
            for (int k = 0; k < int'(TMO); k++) begin
                total++;
                if ({mem_req, mem_we, mem_addr, cache_en, cpu_ack} !== {1'b1, we, addr, 2'b00}) begin
                    bad++;
                    $display("FAIL mem_wait[%0d] req/we/addr/en/ack got=%b/%b/%h/%b/%b want=1/%b/%h/0/0",
                             k, mem_req, mem_we, mem_addr, cache_en, cpu_ack, we, addr);
                end
                if (we) begin
                    total++;
                    if (mem_wdata !== wdata) begin
                        bad++;
                        $display("FAIL mem_wdata got=%h want=%h", mem_wdata, wdata);
                    end
                end
                if (k == lat) begin
                    mem_ready = 1'b1; mem_rdata = mdata;
                end else begin
                    mem_rdata = $urandom;
                end
                step();
                mem_ready = 1'b0; mem_rdata = $urandom;
                if (k == lat) break;
            end
            if (lat >= int'(TMO)) begin
                exp_err = 1'b1;
            end else if (!we) begin
                total++;
                if ({cache_en, cache_read, cache_addr, cache_wdata, cpu_ack}
                    !== {1'b1, 1'b0, addr, mdata, 1'b0}) begin
                    bad++;
                    $display("FAIL fill en/rd/addr/data/ack got=%b/%b/%h/%h/%b want=1/0/%h/%h/0",
                             cache_en, cache_read, cache_addr, cache_wdata, cpu_ack, addr, mdata);
                end
                step();
                exp_rdata = mdata;
            end
        end
        total++;
        if ({cpu_ack, cpu_rdata, cpu_err, mem_req, cache_en} !== {1'b1, exp_rdata, exp_err, 2'b00}) begin
            bad++;
            $display("FAIL resp ack/rdata/err/req/en got=%b/%h/%b/%b/%b want=1/%h/%b/0/0",
                     cpu_ack, cpu_rdata, cpu_err, mem_req, cache_en, exp_rdata, exp_err);
        end
        total++;
        if (hit_cnt !== sat(hits) || miss_cnt !== sat(misses)) begin
            bad++;
            $display("FAIL counters hit/miss got=%0d/%0d want=%0d/%0d",
                     hit_cnt, miss_cnt, sat(hits), sat(misses));
        end
        // cpu_req is still high through the ack cycle and must not start a new request.
        step();
        total++;
        if (cpu_ack !== 1'b0 || cache_en !== 1'b0) begin
            bad++;
            $display("FAIL after_ack ack/en got=%b/%b want=0/0", cpu_ack, cache_en);
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cache_hit = 1'b0; cache_rdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        total++;
        if ({cpu_ack, cpu_rdata, cpu_err, cache_en, cache_read, cache_addr, cache_wdata, mem_req,
             mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b en=%b req=%b hit=%0d miss=%0d want all 0",
                     cpu_ack, cache_en, mem_req, hit_cnt, miss_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_miss();
        run_txn(1'b0, 8'd1, 32'h0, 1'b0, 32'h0, 2, 32'hDEADBEEF);
    endtask

    task automatic test_read_hit();
        run_txn(1'b0, 8'd128, 32'h0, 1'b1, 32'h2, 0, 32'h0);
    endtask

    task automatic test_write_hit();
        run_txn(1'b1, 8'd128, 32'h2, 1'b1, 32'h0, 1, 32'h0);
    endtask

    task automatic test_write_miss();
        run_txn(1'b1, 8'd5, 32'h1234_5678, 1'b0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 8'd77, 32'h0, 1'b0, 32'h0, 99, 32'hCAFE_F00D);
        run_txn(1'b1, 8'd78, 32'h5555_AAAA, 1'b1, 32'h0, 99, 32'h0);
        // Ready on the last allowed cycle wins over the timeout.
        run_txn(1'b0, 8'd79, 32'h0, 1'b0, 32'h0, int'(TMO) - 1, 32'h0BAD_F00D);
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd3;
        step();
        step();
        cache_hit = 1'b0;
        step();
        step();
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre mem_req got=%b want=1", mem_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; cpu_req = 1'b0;
        hits = 0; misses = 0;
        total++;
        if ({mem_req, cache_en, cpu_ack, hit_cnt, miss_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_mid req/en/ack/hit/miss got=%b/%b/%b/%0d/%0d want=0/0/0/0/0",
                     mem_req, cache_en, cpu_ack, hit_cnt, miss_cnt);
        end
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({cpu_ack, mem_req, cache_en} !== 3'b000) begin
                bad++;
                $display("FAIL stray_ready[%0d] ack/req/en got=%b/%b/%b want=0/0/0",
                         i, cpu_ack, mem_req, cache_en);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 8'd10, 32'h0, 1'b1, 32'h1111_1111, 0, 32'h0);
        run_txn(1'b1, 8'd11, 32'h2222_2222, 1'b0, 32'h0, 0, 32'h0);
        run_txn(1'b0, 8'd12, 32'h0, 1'b0, 32'h0, 4, 32'h3333_3333);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? int'(TMO) + 3 : int'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) lat = int'(TMO) - 1;
            run_txn(1'($urandom), 8'($urandom), $urandom, 1'($urandom), $urandom, lat, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
